// File: rtl/gaus_pkg.sv
// gaus_pkg
// Shared constants, FSM state type and window helper for the 7x7 Gaussian
// window generator (gaus_window_gen) and its line buffer (gaus_line_ram).
// Optional build macro used by the top: GAUS_WIN_POS_EN.
package gaus_pkg;

    localparam int KSIZE    = 7;
    localparam int PIX_W    = 8;
    localparam int COL_W    = KSIZE * PIX_W;
    localparam int LB_LINES = KSIZE - 1;
    localparam int LB_W     = LB_LINES * PIX_W;
    localparam int WIN_POS_W = 16;

    // Frame sequencing: FILL primes the line buffers, RUN emits windows.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gausState_e;

    // Shift a window row left by one pixel, inserting the newest pixel on the right.
    function automatic logic [COL_W-1:0] shiftIn(input logic [COL_W-1:0] row,
                                                 input logic [PIX_W-1:0] pix);
        return {row[COL_W-PIX_W-1:0], pix};
    endfunction

endpackage

// File: rtl/gaus_line_ram.sv
// gaus_line_ram
// Simple dual-port RAM with one write port and one registered read port.
// Written as a plain array with a synchronous read so it maps onto block RAM.
// Contents are deliberately not reset.
module gaus_line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 48,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Read port: registered output that holds its value between reads.
    always_ff @(posedge clk) begin
        if (rdEn_i) begin
            rdData_o <= mem[rdAddr_i];
        end
    end

endmodule

// File: rtl/gaus_window_gen.sv
// gaus_window_gen
// Raster-scan front end for the 7x7 Gaussian convolution stage. Six previous
// image lines live in one 48-bit wide line RAM (one byte lane per line); every
// accepted pixel reads its column, shifts the 7x7 window left by one column and
// writes the column back with the oldest line dropped and the new pixel added.
// A start pulse with col1..col7 is issued for every window fully inside the image.
// Optional build macro: GAUS_WIN_POS_EN adds win_x/win_y window-centre outputs.
module gaus_window_gen
    import gaus_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_val,
    output logic [COL_W-1:0] col1,
    output logic [COL_W-1:0] col2,
    output logic [COL_W-1:0] col3,
    output logic [COL_W-1:0] col4,
    output logic [COL_W-1:0] col5,
    output logic [COL_W-1:0] col6,
    output logic [COL_W-1:0] col7,
    output logic             start,
    output logic             frame_done,
    output logic             busy
`ifdef GAUS_WIN_POS_EN
    ,
    output logic [WIN_POS_W-1:0] win_x,
    output logic [WIN_POS_W-1:0] win_y
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_FILLED = YW'(LB_LINES - 1);
    localparam logic [XW-1:0] X_FIRST_WIN = XW'(KSIZE - 1);
    localparam logic [YW-1:0] Y_FIRST_WIN = YW'(KSIZE - 1);

    gausState_e state_q, state_d;
    logic [XW-1:0] xCnt_q, xCnt_d;
    logic [YW-1:0] yCnt_q, yCnt_d;

    logic          accept;
    logic [XW-1:0] pixX;
    logic [YW-1:0] pixY;
    logic          lastCol;
    logic          winPos;

    logic             s1Valid_q;
    logic             s1Start_q;
    logic [PIX_W-1:0] s1Pix_q;
    logic [XW-1:0]    s1Addr_q;

    logic [LB_W-1:0]  lbRdData;
    logic [LB_W-1:0]  lbWrData;

    logic [COL_W-1:0] win_q [KSIZE];
    logic             start_q;
    logic             frameDone_q;
    logic             busy_q;

    // Decide whether this cycle's pixel is taken and where it sits in the frame.
    // A start-of-frame pulse forces the coincident pixel to be (0,0).
    always_comb begin
        accept  = pix_val && (sof || (state_q == FILL) || (state_q == RUN));
        pixX    = sof ? '0 : xCnt_q;
        pixY    = sof ? '0 : yCnt_q;
        lastCol = (pixX == X_LAST);
        winPos  = (pixX >= X_FIRST_WIN) && (pixY >= Y_FIRST_WIN);
    end

    // Raster counters: x wraps at the end of a line and bumps y; y wraps at the
    // end of the frame so the next frame starts clean even without an sof reset.
    always_comb begin
        xCnt_d = xCnt_q;
        yCnt_d = yCnt_q;
        if (sof) begin
            xCnt_d = '0;
            yCnt_d = '0;
        end
        if (accept) begin
            if (lastCol) begin
                xCnt_d = '0;
                yCnt_d = (pixY == Y_LAST) ? '0 : pixY + 1'b1;
            end else begin
                xCnt_d = pixX + 1'b1;
                yCnt_d = pixY;
            end
        end
    end

    // Frame sequencing: FILL until six lines are buffered, RUN to the last pixel,
    // then a single DONE cycle. sof always (re)starts a frame in FILL.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sof) state_d = FILL;
            end
            FILL: begin
                if (sof) begin
                    state_d = FILL;
                end else if (accept && lastCol && (pixY == Y_FILLED)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sof) begin
                    state_d = FILL;
                end else if (accept && lastCol && (pixY == Y_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = sof ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xCnt_q  <= '0;
            yCnt_q  <= '0;
        end else begin
            state_q <= state_d;
            xCnt_q  <= xCnt_d;
            yCnt_q  <= yCnt_d;
        end
    end

    // First pipeline stage: remember the accepted pixel and its column while the
    // line RAM read for that column is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Start_q <= 1'b0;
            s1Pix_q   <= '0;
            s1Addr_q  <= '0;
        end else begin
            s1Valid_q <= accept;
            s1Start_q <= accept && winPos;
            if (accept) begin
                s1Pix_q  <= pix_in;
                s1Addr_q <= pixX;
            end
        end
    end

    // The column written back drops the oldest line (top lane) and appends the
    // new pixel as the most recent line (bottom lane).
    assign lbWrData = {lbRdData[LB_W-PIX_W-1:0], s1Pix_q};

    gaus_line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (LB_W)
    ) u_lineRam (
        .clk      (clk),
        .wrEn_i   (s1Valid_q),
        .wrAddr_i (s1Addr_q),
        .wrData_i (lbWrData),
        .rdEn_i   (accept),
        .rdAddr_i (pixX),
        .rdData_o (lbRdData)
    );

    // Window shift: RAM lanes feed rows 0..5 (oldest line first), the delayed
    // pixel feeds row 6. Rows only move on accepted pixels so gaps freeze them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < KSIZE; r++) begin
                win_q[r] <= '0;
            end
        end else if (s1Valid_q) begin
            for (int r = 0; r < LB_LINES; r++) begin
                win_q[r] <= shiftIn(win_q[r], lbRdData[(LB_LINES-1-r)*PIX_W +: PIX_W]);
            end
            win_q[KSIZE-1] <= shiftIn(win_q[KSIZE-1], s1Pix_q);
        end
    end

    // Output pulses. A restart squashes a window still in the pipeline; busy
    // spans from sof to the cycle frame_done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_q     <= s1Start_q && !sof;
            frameDone_q <= (state_q == DONE);
            busy_q      <= sof || (busy_q && (state_q != DONE));
        end
    end

`ifdef GAUS_WIN_POS_EN
    logic [YW-1:0]        s1Y_q;
    logic [WIN_POS_W-1:0] winX_q;
    logic [WIN_POS_W-1:0] winY_q;

    // Track the row of the in-flight pixel so the window centre can be reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Y_q <= '0;
        end else if (accept) begin
            s1Y_q <= pixY;
        end
    end

    // Window centre sits three pixels up and left of the newest pixel; it is
    // updated together with start so both describe the same window.
    always_ff @(posedge clk) begin
        if (rst) begin
            winX_q <= '0;
            winY_q <= '0;
        end else if (s1Start_q && !sof) begin
            winX_q <= WIN_POS_W'(s1Addr_q) - WIN_POS_W'(3);
            winY_q <= WIN_POS_W'(s1Y_q) - WIN_POS_W'(3);
        end
    end

    assign win_x = winX_q;
    assign win_y = winY_q;
`endif

    assign col1       = win_q[0];
    assign col2       = win_q[1];
    assign col3       = win_q[2];
    assign col4       = win_q[3];
    assign col5       = win_q[4];
    assign col6       = win_q[5];
    assign col7       = win_q[6];
    assign start      = start_q;
    assign frame_done = frameDone_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gaus_window_gen.sv
// tb_gaus_window_gen
// Directed bench for gaus_window_gen on an 8x8 image. Pixel value is
// (y*16+x) xor a per-frame base. Each driven cycle records whether that pixel
// must produce a window; the next sampled cycle must show start accordingly
// and, when it does, the full window is compared with one rebuilt from the image.
// Build with GAUS_WIN_POS_EN defined to also check win_x/win_y.
module tb_gaus_window_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_val = 1'b0;
    logic [55:0] col1, col2, col3, col4, col5, col6, col7;
    logic        start;
    logic        frame_done;
    logic        busy;
`ifdef GAUS_WIN_POS_EN
    logic [15:0] win_x;
    logic [15:0] win_y;
`endif

    int assertCount = 0;
    int failCount   = 0;
    int startCount  = 0;
    int doneCount   = 0;

    bit         prevFlag = 1'b0;
    bit         prevDone = 1'b0;
    int         prevX    = 0;
    int         prevY    = 0;
    logic [7:0] prevBase = '0;

    gaus_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_in     (pix_in),
        .pix_val    (pix_val),
        .col1       (col1),
        .col2       (col2),
        .col3       (col3),
        .col4       (col4),
        .col5       (col5),
        .col6       (col6),
        .col7       (col7),
        .start      (start),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef GAUS_WIN_POS_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] pixVal(input logic [7:0] base, input int y, input int x);
        return 8'(y * 16 + x) ^ base;
    endfunction

    // Window expected for newest pixel (cx,cy): col1 (oldest line) in the top
    // 56 bits, leftmost pixel in the top byte of each row.
    function automatic logic [391:0] expWindow(input logic [7:0] base, input int cx, input int cy);
        logic [391:0] w;
        w = '0;
        for (int r = 0; r < 7; r++) begin
            for (int j = 0; j < 7; j++) begin
                w[(6-r)*56 + (6-j)*8 +: 8] = pixVal(base, cy - 6 + r, cx - 6 + j);
            end
        end
        return w;
    endfunction

    task automatic checkEq(input string tag, input logic [391:0] obs, input logic [391:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle checks against what the previous driven cycle promised.
    task automatic checkOutput();
        if (start === 1'b1) startCount++;
        if (frame_done === 1'b1) doneCount++;
        checkEq("start_pulse", 392'(start), 392'(prevFlag));
        checkEq("frame_done_pulse", 392'(frame_done), 392'(prevDone));
        if (prevFlag) begin
            checkEq("window", {col1, col2, col3, col4, col5, col6, col7},
                    expWindow(prevBase, prevX, prevY));
            if (prevBase == 8'h00 && prevX == 6 && prevY == 6) begin
                checkEq("first_col1", 392'(col1), 392'(56'h00010203040506));
                checkEq("first_col7", 392'(col7), 392'(56'h60616263646566));
            end
            if (prevBase == 8'h00 && prevX == 7 && prevY == 7) begin
                checkEq("last_col1", 392'(col1), 392'(56'h11121314151617));
                checkEq("last_col7", 392'(col7), 392'(56'h71727374757677));
            end
`ifdef GAUS_WIN_POS_EN
            checkEq("win_x", 392'(win_x), 392'(prevX - 3));
            checkEq("win_y", 392'(win_y), 392'(prevY - 3));
`endif
        end
    endtask

    // Drive one cycle, sample just after the edge, then record this cycle's promise.
    task automatic applyStimulus(input logic rstV, input logic sofV, input logic valV,
                                 input logic [7:0] pixV, input bit flagV, input int fx,
                                 input int fy, input bit doneV, input logic [7:0] baseV);
        rst     = rstV;
        sof     = sofV;
        pix_val = valV;
        pix_in  = pixV;
        @(posedge clk);
        #1;
        checkOutput();
        prevFlag = flagV;
        prevX    = fx;
        prevY    = fy;
        prevDone = doneV;
        prevBase = baseV;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, 0, 0, 1'b0, 8'h00);
    endtask

    // Send the first nPix pixels of a frame in raster order.
    task automatic driveFrame(input logic [7:0] base, input bit gaps, input bit sofWithFirst,
                              input int nPix, input bit squashLast);
        int  x;
        int  y;
        int  nGap;
        bit  f;
        startCount = 0;
        doneCount  = 0;
        if (!sofWithFirst) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0, 0, 0, 1'b0, base);
        end
        for (int i = 0; i < nPix; i++) begin
            x = i % W;
            y = i / W;
            f = (x >= 6) && (y >= 6) && !(squashLast && (i == nPix - 1));
            applyStimulus(1'b0, (sofWithFirst && i == 0), 1'b1, pixVal(base, y, x),
                          f, x, y, (i == W * H - 1), base);
            if (gaps) begin
                nGap = 1 + $urandom_range(0, 2);
                repeat (nGap) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, 0, 0, 1'b0, base);
            end
        end
    endtask

    task automatic checkFrameEnd();
        idle(3);
        checkEq("start_count", 392'(startCount), 392'(4));
        checkEq("done_count", 392'(doneCount), 392'(1));
        checkEq("busy_after_frame", 392'(busy), 392'(0));
    endtask

    initial begin
        // Reset and its output state.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0, 8'h00);
        checkEq("reset_window", {col1, col2, col3, col4, col5, col6, col7}, '0);
        checkEq("reset_busy", 392'(busy), 392'(0));
        idle(2);

        // Continuous frame, sof together with the first pixel.
        driveFrame(8'h00, 1'b0, 1'b1, W * H, 1'b0);
        checkFrameEnd();

        // Same image with stalls between pixels, sof one cycle ahead.
        driveFrame(8'h00, 1'b1, 1'b0, W * H, 1'b0);
        checkFrameEnd();

        // Abort in row 4, abort again with a window in flight, then a clean frame.
        driveFrame(8'hA5, 1'b0, 1'b1, 4 * W + 3, 1'b0);
        checkEq("busy_mid_frame", 392'(busy), 392'(1));
        driveFrame(8'h33, 1'b0, 1'b1, 6 * W + 7, 1'b1);
        driveFrame(8'hC3, 1'b0, 1'b1, W * H, 1'b0);
        checkFrameEnd();

        // Reset during RUN with a window in flight; pixels without sof are ignored.
        driveFrame(8'h3C, 1'b0, 1'b1, 6 * W + 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 0, 0, 1'b0, 8'h00);
        checkEq("rst_window", {col1, col2, col3, col4, col5, col6, col7}, '0);
        checkEq("rst_busy", 392'(busy), 392'(0));
        startCount = 0;
        repeat (3 * W) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 0, 0, 1'b0, 8'h00);
        checkEq("no_start_without_sof", 392'(startCount), 392'(0));
        checkEq("busy_without_sof", 392'(busy), 392'(0));
        driveFrame(8'h5A, 1'b0, 1'b1, W * H, 1'b0);
        checkFrameEnd();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
